serial_add_sub_ctrl: RTL
========================

# serial_add_sub_ctrl

Bit-serial sequencer for the 1-bit `add_sub` full adder/subtractor cell. It accepts a pair of WIDTH-bit operands and an add/subtract select, then drives the cell one bit per clock, LSB first. Between bits it holds the carry/borrow in a register and assembles the WIDTH-bit result, carry/borrow-out and signed-overflow flag. It sits between a requesting unit (start/done handshake) and one `add_sub` instance wired to its `cell_*` ports.

## Interface

- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2

- clk  input  1  rising-edge clock, the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse/level; sampled only in IDLE
- op  input  1  0 = add (a + b), 1 = subtract (a - b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cell_a  output  1  to add_sub.a
- cell_b  output  1  to add_sub.b
- cell_c  output  1  to add_sub.c (carry/borrow in)
- cell_sel  output  1  to add_sub.sel
- cell_sd  input  1  from add_sub.sd (sum/difference)
- cell_cb  input  1  from add_sub.cb (carry/borrow out)
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion strobe
- result  output  WIDTH  registered result, held until the next completion
- cout  output  1  final carry (add) or borrow (sub), held with result
- ovf  output  1  two's-complement overflow, held with result

## Operation

- Cell contract, combinational:
  - sd = a^b^c.
  - sel=0: cb = ab | ac | bc.
  - sel=1: cb = ~a·b | ~a·c | b·c (borrow of a−b−c).
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1 at a clock edge:
  - latch a, b and op into shift registers sa, sb and op_q;
  - clear carry register cr and bit counter cnt;
  - go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, cell drive: cell_a=sa[0], cell_b=sb[0], cell_c=cr, cell_sel=op_q.
- RUN, each edge:
  - acc <= {cell_sd, acc[WIDTH-1:1]}; cr <= cell_cb;
  - sa and sb shift right by one; cnt increments.
- RUN, on the edge where cnt == WIDTH-1:
  - result <= {cell_sd, acc[WIDTH-1:1]}; cout <= cell_cb;
  - ovf computed from the latched operand MSBs and the new result MSB:
    - add: A[msb]==B[msb] and R[msb]!=A[msb];
    - sub: A[msb]!=B[msb] and R[msb]!=A[msb];
  - go to DONE.
- DONE: done=1 for this single cycle, then unconditional transition to IDLE.
- Width rules:
  - result is modulo 2^WIDTH.
  - cout is the unsigned carry-out for add and the unsigned borrow for sub (1 iff A < B).
  - cnt width is ceil(log2(WIDTH)), minimum 1.
- Outside RUN, cell_a, cell_b and cell_c are driven 0 and cell_sel = op_q.
- start is ignored in RUN and in DONE. No queuing, no error flag.
- op, a and b may change freely after the sampling edge without affecting the operation in flight.
- result, cout and ovf change only on the RUN→DONE edge. They are stable during any later operation until that operation completes.

## Timing

- Reset values, asserted asynchronously on rst_n fall:
  - state IDLE; busy=0, done=0;
  - result=0, cout=0, ovf=0;
  - cell_a=cell_b=cell_c=cell_sel=0;
  - all internal registers 0.
- Reset during RUN or DONE aborts the operation. No done pulse is produced, and prior result/cout/ovf are lost (set to 0).
- Sampling edge E0 (IDLE, start=1):
  - busy=1 in cycles E0+1 … E0+WIDTH;
  - done=1 in cycle E0+WIDTH+1, with result valid in the same cycle;
  - IDLE again from E0+WIDTH+2.
- Start-to-done latency is WIDTH+1 cycles. With start held high, the minimum issue interval is WIDTH+2 cycles.
- cell_* outputs are combinational from registers only (no input-to-output path). cell_sd and cell_cb are sampled at the same edge.

## Test plan

- WIDTH=8, add, a=8'h5A, b=8'h33 → result=8'h8D, cout=0, ovf=1. busy is high for exactly 8 cycles; done pulses once, 9 cycles after the sampling edge.
- Add, a=8'hFF, b=8'h01 → result=8'h00, cout=1, ovf=0. Check each cell_c value per bit: 0, 1, 1, 1, 1, 1, 1, 1.
- Sub, a=8'h10, b=8'h20 → result=8'hF0, cout=1 (borrow), ovf=0. Then sub, a=8'h80, b=8'h01 → result=8'h7F, cout=0, ovf=1.
- Start add 8'h01+8'h01; pulse start with op=1, a=8'hAA, b=8'h55 during RUN cycle 3 and during the DONE cycle → both pulses ignored; result=8'h02, a single done pulse, and the block returns to IDLE with busy=0.
- start held high with fixed add operands 8'h0F, 8'h01 → done pulses every 10 cycles; result=8'h10 on every completion; result stays stable between completions.
- Assert rst_n=0 in the 4th RUN cycle of an add → all outputs are 0 immediately, asynchronously, and no done follows. After release, add 8'h7F+8'h01 → result=8'h80, cout=0, ovf=1.

Source files
------------

// File: rtl/serial_add_sub_ctrl_if.sv
// rtl/serial_add_sub_ctrl_if.sv - request/completion bundle between a requesting unit and the serial add/sub sequencer
interface serial_add_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub_ctrl.sv
// rtl/serial_add_sub_ctrl.sv - bit-serial LSB-first sequencer driving one 1-bit add/sub cell
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sub_ctrl_if.slave  req,
    output logic                  cell_a,
    output logic                  cell_b,
    output logic                  cell_c,
    output logic                  cell_sel,
    input  logic                  cell_sd,
    input  logic                  cell_cb
);
    localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             op_q;
    logic             cr;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    // acc holds the WIDTH-1 most recent sum bits; the final bit comes straight from the cell
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_shift;
    logic             ovf_next;

    // Cell inputs come only from registers so there is no input-to-output path
    assign cell_a   = (state == RUN) ? sa[0] : 1'b0;
    assign cell_b   = (state == RUN) ? sb[0] : 1'b0;
    assign cell_c   = (state == RUN) ? cr    : 1'b0;
    assign cell_sel = op_q;

    // New sum bit enters at the top; after the last bit this is the complete result
    assign acc_shift = {cell_sd, acc};

    // Overflow from the latched operand sign bits and the sign of the finished result
    always_comb begin
        ovf_next = 1'b0;
        if (op_q) begin
            ovf_next = (a_msb != b_msb) && (cell_sd != a_msb);
        end else begin
            ovf_next = (a_msb == b_msb) && (cell_sd != a_msb);
        end
    end

    // Sequencer: sample operands in IDLE, one bit per clock in RUN, one-cycle done strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            op_q       <= 1'b0;
            cr         <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            acc        <= '0;
            req.busy   <= 1'b0;
            req.done   <= 1'b0;
            req.result <= '0;
            req.cout   <= 1'b0;
            req.ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req.done <= 1'b0;
                    if (req.start) begin
                        sa       <= req.a;
                        sb       <= req.b;
                        op_q     <= req.op;
                        a_msb    <= req.a[WIDTH-1];
                        b_msb    <= req.b[WIDTH-1];
                        cr       <= 1'b0;
                        cnt      <= '0;
                        req.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_shift[WIDTH-1:1];
                    cr  <= cell_cb;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        req.result <= acc_shift;
                        req.cout   <= cell_cb;
                        req.ovf    <= ovf_next;
                        req.busy   <= 1'b0;
                        req.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    req.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    req.busy <= 1'b0;
                    req.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
